// File: rtl/ber_sync_sequencer.sv
// BER measurement sequencer: sweeps PRBS delay taps for the best alignment,
// locks to it, then counts samples and errors over a measurement window.
module ber_sync_sequencer #(
  parameter int OS_FACTOR = 4,
  parameter int NB_ADDR   = 10,
  parameter int NB_COUNT  = 9,
  parameter int NB_ACC    = 64,
  parameter int MEAS_LEN  = 4096,
  parameter int ZERO_EXIT = 1
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_err,
  output logic                o_smp_strobe,
  output logic [NB_ADDR-1:0]  o_delay_sel,
  output logic                o_busy,
  output logic                o_locked,
  output logic                o_done,
  output logic [NB_ADDR-1:0]  o_best_delay,
  output logic [NB_COUNT-1:0] o_min_errs,
  output logic [NB_ACC-1:0]   o_samples,
  output logic [NB_ACC-1:0]   o_errors
);

  localparam int NB_PH = (OS_FACTOR > 2) ? $clog2(OS_FACTOR) : 1;
  localparam logic [NB_PH-1:0] PH_LAST = NB_PH'(OS_FACTOR - 1);
  localparam logic [NB_COUNT-1:0] WIN_LAST =
    NB_COUNT'((2 ** NB_COUNT) - 2);
  localparam logic [NB_ADDR-1:0] TAP_LAST = '1;
  localparam logic [NB_ACC-1:0] ACC_MAX = '1;
  localparam logic [NB_ACC-1:0] MEAS_CMP = NB_ACC'(MEAS_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_MEAS,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [NB_PH-1:0]    r_phase;
  logic [NB_COUNT-1:0] r_win;
  logic [NB_COUNT-1:0] r_acc;
  logic [NB_COUNT-1:0] r_min;

  logic [NB_PH-1:0]    w_ph_nxt;
  logic [NB_COUNT-1:0] w_acc_nxt;
  logic                w_better;
  logic [NB_ADDR-1:0]  w_best_nxt;
  logic [NB_ACC-1:0]   w_smp_nxt;
  logic [NB_ACC-1:0]   w_errs_nxt;
  logic                w_meas_end;

  assign o_min_errs = r_min;

  assign w_ph_nxt   = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
  assign w_acc_nxt  = r_acc + NB_COUNT'(i_err);
  assign w_better   = w_acc_nxt < r_min;
  assign w_best_nxt = w_better ? o_delay_sel : o_best_delay;
  assign w_smp_nxt  = (o_samples == ACC_MAX) ? o_samples
                                             : o_samples + 1'b1;
  assign w_errs_nxt = (!i_err || o_errors == ACC_MAX) ? o_errors
                                                      : o_errors + 1'b1;
  assign w_meas_end = (MEAS_LEN != 0) && (w_smp_nxt == MEAS_CMP);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_win        <= '0;
      r_acc        <= '0;
      r_min        <= '1;
      o_smp_strobe <= 1'b0;
      o_delay_sel  <= '0;
      o_busy       <= 1'b0;
      o_locked     <= 1'b0;
      o_done       <= 1'b0;
      o_best_delay <= '0;
      o_samples    <= '0;
      o_errors     <= '0;
    end else if (i_abort) begin
      // results stay visible after an abort
      r_state      <= S_IDLE;
      r_phase      <= '0;
      o_smp_strobe <= 1'b0;
      o_busy       <= 1'b0;
      o_locked     <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_ALIGN;
            r_phase      <= '0;
            r_win        <= '0;
            r_acc        <= '0;
            r_min        <= '1;
            o_smp_strobe <= 1'b0;
            o_delay_sel  <= '0;
            o_busy       <= 1'b1;
            o_locked     <= 1'b0;
            o_done       <= 1'b0;
            o_best_delay <= '0;
            o_samples    <= '0;
            o_errors     <= '0;
          end
        end
        S_ALIGN: begin
          r_phase      <= w_ph_nxt;
          o_smp_strobe <= (w_ph_nxt == PH_LAST);
          if (o_smp_strobe) begin
            r_acc <= w_acc_nxt;
            r_win <= r_win + 1'b1;
            if (r_win == WIN_LAST) begin
              if (w_better) begin
                r_min        <= w_acc_nxt;
                o_best_delay <= o_delay_sel;
              end
              if (ZERO_EXIT != 0 && w_acc_nxt == '0) begin
                r_state      <= S_MEAS;
                r_phase      <= '0;
                o_smp_strobe <= 1'b0;
                o_locked     <= 1'b1;
              end else if (o_delay_sel == TAP_LAST) begin
                r_state      <= S_MEAS;
                r_phase      <= '0;
                o_smp_strobe <= 1'b0;
                o_locked     <= 1'b1;
                o_delay_sel  <= w_best_nxt;
              end else begin
                o_delay_sel <= o_delay_sel + 1'b1;
                r_acc       <= '0;
                r_win       <= '0;
              end
            end
          end
        end
        S_MEAS: begin
          r_phase      <= w_ph_nxt;
          o_smp_strobe <= (w_ph_nxt == PH_LAST);
          if (o_smp_strobe) begin
            o_samples <= w_smp_nxt;
            o_errors  <= w_errs_nxt;
            if (w_meas_end) begin
              r_state      <= S_DONE;
              r_phase      <= '0;
              o_smp_strobe <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_sync_sequencer.sv
// Bench for ber_sync_sequencer: three parameter sets run side by side,
// checked every cycle against a behavioural model plus fixed expectations.
module tb_ber_sync_sequencer;

  localparam int OS   = 4;
  localparam int WIN  = 15;
  localparam int NDLY = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic e_in [3];
  int   mode = 2;

  logic       stb_o [3];
  logic       busy_o [3];
  logic       lck_o [3];
  logic       done_o [3];
  logic [2:0] dsel_o [3];
  logic [2:0] best_o [3];
  logic [3:0] min_o [3];
  logic [7:0] smp0, ers0, smp1, ers1;
  logic [5:0] smp2, ers2;

  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ber_sync_sequencer #(.OS_FACTOR(4), .NB_ADDR(3), .NB_COUNT(4),
    .NB_ACC(8), .MEAS_LEN(32), .ZERO_EXIT(0)) u0 (
    .clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_err(e_in[0]), .o_smp_strobe(stb_o[0]), .o_delay_sel(dsel_o[0]),
    .o_busy(busy_o[0]), .o_locked(lck_o[0]), .o_done(done_o[0]),
    .o_best_delay(best_o[0]), .o_min_errs(min_o[0]),
    .o_samples(smp0), .o_errors(ers0));

  ber_sync_sequencer #(.OS_FACTOR(4), .NB_ADDR(3), .NB_COUNT(4),
    .NB_ACC(8), .MEAS_LEN(32), .ZERO_EXIT(1)) u1 (
    .clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_err(e_in[1]), .o_smp_strobe(stb_o[1]), .o_delay_sel(dsel_o[1]),
    .o_busy(busy_o[1]), .o_locked(lck_o[1]), .o_done(done_o[1]),
    .o_best_delay(best_o[1]), .o_min_errs(min_o[1]),
    .o_samples(smp1), .o_errors(ers1));

  ber_sync_sequencer #(.OS_FACTOR(4), .NB_ADDR(3), .NB_COUNT(4),
    .NB_ACC(6), .MEAS_LEN(0), .ZERO_EXIT(0)) u2 (
    .clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_err(e_in[2]), .o_smp_strobe(stb_o[2]), .o_delay_sel(dsel_o[2]),
    .o_busy(busy_o[2]), .o_locked(lck_o[2]), .o_done(done_o[2]),
    .o_best_delay(best_o[2]), .o_min_errs(min_o[2]),
    .o_samples(smp2), .o_errors(ers2));

  function automatic int p_zx(int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int p_ml(int k);
    return (k == 2) ? 0 : 32;
  endfunction
  function automatic int p_amx(int k);
    return (k == 2) ? 63 : 255;
  endfunction

  // error pattern seen by a DUT, as a function of its tap and sample
  function automatic logic errf(int md, int st, int tap, int nwin);
    case (md)
      3: return (tap == 2 || tap == 6) ? (nwin < 3) : 1'b1;
      4: return tap != 3;
      6: return (st == 2) ? 1'b1 : (tap != 5);
      default: return tap != 5;
    endcase
  endfunction

  // model: st 0 idle, 1 align, 2 measure, 3 done; cyc = clocks since entry
  int m_st [3], m_cyc [3], m_tap [3], m_nwin [3], m_acc [3];
  int m_min [3], m_best [3], m_smp [3], m_ers [3];
  bit m_on = 0;

  always @(posedge clk) begin
    bit s;
    for (int k = 0; k < 3; k++) begin
      s = (m_st[k] == 1 || m_st[k] == 2) && (m_cyc[k] % OS == OS - 1);
      if (rst) begin
        m_on = 1;
        m_st[k] = 0; m_cyc[k] = 0; m_tap[k] = 0; m_nwin[k] = 0;
        m_acc[k] = 0; m_min[k] = 15; m_best[k] = 0;
        m_smp[k] = 0; m_ers[k] = 0;
      end else if (abort) begin
        m_st[k] = 0;
        m_cyc[k] = 0;
      end else if (m_st[k] == 0 || m_st[k] == 3) begin
        if (start) begin
          m_st[k] = 1; m_cyc[k] = 0; m_tap[k] = 0; m_nwin[k] = 0;
          m_acc[k] = 0; m_min[k] = 15; m_best[k] = 0;
          m_smp[k] = 0; m_ers[k] = 0;
        end
      end else begin
        m_cyc[k]++;
        if (s && m_st[k] == 1) begin
          m_acc[k] += int'(e_in[k]);
          m_nwin[k]++;
          if (m_nwin[k] == WIN) begin
            if (m_acc[k] < m_min[k]) begin
              m_min[k] = m_acc[k];
              m_best[k] = m_tap[k];
            end
            if (p_zx(k) == 1 && m_acc[k] == 0) begin
              m_st[k] = 2; m_cyc[k] = 0;
            end else if (m_tap[k] == NDLY - 1) begin
              m_st[k] = 2; m_cyc[k] = 0; m_tap[k] = m_best[k];
            end else begin
              m_tap[k]++; m_acc[k] = 0; m_nwin[k] = 0;
            end
          end
        end else if (s) begin
          if (m_smp[k] < p_amx(k)) m_smp[k]++;
          if (e_in[k] && m_ers[k] < p_amx(k)) m_ers[k]++;
          if (p_ml(k) != 0 && m_smp[k] == p_ml(k)) m_st[k] = 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    longint gs, ge, ws;
    int wb, wl, wd;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_on) begin
        gs = (k == 0) ? longint'(smp0) : (k == 1) ? longint'(smp1)
                                                  : longint'(smp2);
        ge = (k == 0) ? longint'(ers0) : (k == 1) ? longint'(ers1)
                                                  : longint'(ers2);
        wb = (m_st[k] == 1 || m_st[k] == 2) ? 1 : 0;
        wl = (m_st[k] == 2 || m_st[k] == 3) ? 1 : 0;
        wd = (m_st[k] == 3) ? 1 : 0;
        ws = (wb == 1 && m_cyc[k] % OS == OS - 1) ? 1 : 0;
        checks++;
        if (longint'(stb_o[k]) != ws || int'(dsel_o[k]) != m_tap[k] ||
            int'(busy_o[k]) != wb || int'(lck_o[k]) != wl ||
            int'(done_o[k]) != wd || int'(best_o[k]) != m_best[k] ||
            int'(min_o[k]) != m_min[k] || gs != longint'(m_smp[k]) ||
            ge != longint'(m_ers[k])) begin
          errs++;
          $display("FAIL model_u%0d t=%0t got stb%0d sel%0d b%0d l%0d d%0d best%0d min%0d smp%0d err%0d want stb%0d sel%0d b%0d l%0d d%0d best%0d min%0d smp%0d err%0d",
            k, $time, stb_o[k], dsel_o[k], busy_o[k], lck_o[k],
            done_o[k], best_o[k], min_o[k], gs, ge, ws, m_tap[k], wb,
            wl, wd, m_best[k], m_min[k], m_smp[k], m_ers[k]);
        end
      end
      e_in[k] = errf(mode, m_st[k], m_tap[k], m_nwin[k]);
    end
  end

  task automatic chk(string nm, longint got, longint want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int cyc, nstb, mx;

  initial begin
    for (int k = 0; k < 3; k++) e_in[k] = 1'b0;
    // 1) reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobe", longint'(stb_o[0]), 0);
    chk("rst_sel", longint'(dsel_o[0]), 0);
    chk("rst_busy", longint'(busy_o[0]), 0);
    chk("rst_locked", longint'(lck_o[0]), 0);
    chk("rst_done", longint'(done_o[0]), 0);
    chk("rst_best", longint'(best_o[0]), 0);
    chk("rst_samples", longint'(smp0), 0);
    chk("rst_errors", longint'(ers0), 0);
    nstb = 0;
    repeat (20) begin
      @(negedge clk);
      nstb += int'(stb_o[0]) + int'(stb_o[1]) + int'(stb_o[2]);
    end
    chk("idle_strobes", nstb, 0);

    // 2) full sweep, only tap 5 clean
    mode = 2;
    pulse_start();
    cyc = 0; nstb = 0;
    while (!done_o[0] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      nstb += int'(stb_o[0]);
    end
    chk("t2_cycles", cyc, 608);
    chk("t2_strobes", nstb, 152);
    chk("t2_best", longint'(best_o[0]), 5);
    chk("t2_min", longint'(min_o[0]), 0);
    chk("t2_sel", longint'(dsel_o[0]), 5);
    chk("t2_locked", longint'(lck_o[0]), 1);
    chk("t2_samples", longint'(smp0), 32);
    chk("t2_errors", longint'(ers0), 0);

    // 3) tie between taps 2 and 6, lower tap wins
    mode = 3;
    pulse_start();
    cyc = 0;
    while (!done_o[0] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_cycles", cyc, 608);
    chk("t3_best", longint'(best_o[0]), 2);
    chk("t3_min", longint'(min_o[0]), 3);
    chk("t3_sel", longint'(dsel_o[0]), 2);

    // 4) zero-error early exit at tap 3
    mode = 4;
    pulse_start();
    cyc = 0; mx = 0;
    while (!lck_o[1] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (int'(dsel_o[1]) > mx) mx = int'(dsel_o[1]);
    end
    chk("t4_cycles", cyc, 240);
    chk("t4_maxtap", mx, 3);
    chk("t4_sel", longint'(dsel_o[1]), 3);
    chk("t4_best", longint'(best_o[1]), 3);
    cyc = 0;
    while (!done_o[0] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_u0_done", longint'(done_o[0]), 1);

    // 5) abort after the 10th measurement strobe
    mode = 2;
    pulse_start();
    cyc = 0;
    while (smp0 != 8'd10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_cycles", cyc, 480 + 40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", longint'(busy_o[0]), 0);
    chk("t5_locked", longint'(lck_o[0]), 0);
    chk("t5_samples", longint'(smp0), 10);
    chk("t5_best", longint'(best_o[0]), 5);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_both_busy", longint'(busy_o[0]), 0);
    chk("t5_both_samples", longint'(smp0), 10);

    // 6) free-running measurement saturates
    mode = 6;
    pulse_start();
    cyc = 0;
    while (!lck_o[2] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_lock_cycles", cyc, 480);
    nstb = 0; cyc = 0;
    while (nstb < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      nstb += int'(stb_o[2]);
    end
    @(negedge clk);
    chk("t6_strobes", nstb, 100);
    chk("t6_samples", longint'(smp2), 63);
    chk("t6_errors", longint'(ers2), 63);
    chk("t6_done", longint'(done_o[2]), 0);
    chk("t6_busy", longint'(busy_o[2]), 1);

    // mid-operation reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", longint'(busy_o[2]), 0);
    chk("mrst_samples", longint'(smp2), 0);
    chk("mrst_min", longint'(min_o[2]), 15);
    chk("mrst_sel", longint'(dsel_o[2]), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
